// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-back control slice.
package regfile_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    // Bit positions of each requester in the arbiter req/gnt vectors.
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;

    // Identity of the requester that won the most recent accepted transfer.
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational from req and the
// stored last winner; the stored winner only advances on an accepted transfer.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    grant_e r_last_grant;

    // Pick a winner: sole requester wins, contention goes to the one not served last.
    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_last_grant == GNT_MEM) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    // Remember who was served last; reset favours the ALU on first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= GNT_MEM;
        end else if (accept) begin
            r_last_grant <= gnt[REQ_ALU] ? GNT_ALU : GNT_MEM;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: shares the register file's single write port between
// the ALU and load write-back paths, tracks outstanding writes per register,
// and reports read-after-write hazards to decode.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned XLEN     = regfile_ctrl_pkg::XLEN,
    parameter int unsigned NUM_REGS = regfile_ctrl_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_ctrl_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [XLEN-1:0]     mem_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   chk_rs1,
    input  logic [ADDR_W-1:0]   chk_rs2,
    output logic                hazard,
    output logic                rf_write_enable,
    output logic [ADDR_W-1:0]   rf_write_reg,
    output logic [XLEN-1:0]     rf_write_data,
    output logic [NUM_REGS-1:0] pending,
    output logic                proto_err
);

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_alu_acc;
    logic                w_mem_acc;
    logic                w_acc;
    logic [ADDR_W-1:0]   w_acc_rd;
    logic [XLEN-1:0]     w_acc_data;
    logic                w_acc_writes;
    logic                w_claim;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic                w_haz_rs1;
    logic                w_haz_rs2;

    logic                r_we;
    logic [ADDR_W-1:0]   r_wreg;
    logic [XLEN-1:0]     r_wdata;
    logic [NUM_REGS-1:0] r_pending;
    logic                r_proto_err;

    assign w_req[REQ_ALU] = alu_valid;
    assign w_req[REQ_MEM] = mem_valid;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (w_req),
        .accept (w_acc),
        .gnt    (w_gnt)
    );

    // Handshake: the arbiter only grants active requesters, so a grant is an acceptance.
    always_comb begin
        w_alu_acc    = alu_valid & w_gnt[REQ_ALU];
        w_mem_acc    = mem_valid & w_gnt[REQ_MEM];
        w_acc        = w_alu_acc | w_mem_acc;
        w_acc_rd     = w_alu_acc ? alu_rd   : mem_rd;
        w_acc_data   = w_alu_acc ? alu_data : mem_data;
        w_acc_writes = w_acc && (w_acc_rd != '0);
        w_claim      = issue_valid && (issue_rd != '0);
    end

    assign alu_ready = w_alu_acc;
    assign mem_ready = w_mem_acc;

    // Registered write port: one cycle after acceptance; x0 writes are swallowed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_acc_writes;
            if (w_acc_writes) begin
                r_wreg  <= w_acc_rd;
                r_wdata <= w_acc_data;
            end
        end
    end

    // Next scoreboard: clear the written register first so a same-cycle claim wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_acc_writes) begin
            w_pending_nxt[w_acc_rd] = 1'b0;
        end
        if (w_claim) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
    end

    // Scoreboard and sticky double-claim flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_claim && r_pending[issue_rd]) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Hazard: outstanding claim, or the write is committing at the coming edge
    // (pending is already clear then, but the file still holds the stale value).
    always_comb begin
        w_haz_rs1 = (chk_rs1 != '0) &&
                    (r_pending[chk_rs1] || (r_we && (r_wreg == chk_rs1)));
        w_haz_rs2 = (chk_rs2 != '0) &&
                    (r_pending[chk_rs2] || (r_we && (r_wreg == chk_rs2)));
        hazard    = w_haz_rs1 || w_haz_rs2;
    end

    assign rf_write_enable = r_we;
    assign rf_write_reg    = r_wreg;
    assign rf_write_data   = r_wdata;
    assign pending         = r_pending;
    assign proto_err       = r_proto_err;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 register file. It shares the file's single write port between two producers, the ALU write-back and the memory/load write-back, using round-robin arbitration and valid/ready handshakes. A pending-write scoreboard drives a hazard signal for the decode stage. The block sits between the execute/memory stages and the register file write port (write_enable/write_reg/write_data).

Parameters:
XLEN, 32, data width of the register file
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register address width (log2 NUM_REGS)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU write-back request
alu_ready  out  1  ALU request granted this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  XLEN  ALU result
mem_valid  in  1  load write-back request
mem_ready  out  1  load request granted this cycle
mem_rd  in  ADDR_W  load destination register
mem_data  in  XLEN  load data
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_rd  in  ADDR_W  destination register being claimed
chk_rs1  in  ADDR_W  source register 1 to check
chk_rs2  in  ADDR_W  source register 2 to check
hazard  out  1  a checked source has an uncommitted write
rf_write_enable  out  1  register file write enable (registered)
rf_write_reg  out  ADDR_W  register file write address (registered)
rf_write_data  out  XLEN  register file write data (registered)
pending  out  NUM_REGS  scoreboard, bit n = write to xn outstanding
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: rf_write_enable=0, rf_write_reg=0, rf_write_data=0, pending=0, proto_err=0, last_grant=MEM (so ALU wins first contention). Reset asserted mid-operation drops any in-flight write: rf_write_enable is 0 in the cycle after reset.
- Arbitration (combinational): at most one ready per cycle.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not named by last_grant wins.
  - last_grant updates only on an accepted transfer (valid&&ready).
  - ready is never asserted without the matching valid.
- Requester rule: a requester must hold valid/rd/data stable until accepted. The block does not check this.
- Write port: 1-cycle latency. On acceptance at edge N, rf_write_enable=1 with the accepted rd/data during cycle N+1. Otherwise rf_write_enable=0.
- x0: an accepted request with rd=0 is consumed (ready=1), but rf_write_enable stays 0 and pending is unaffected.
- Scoreboard update at each edge:
  - Clear pending[rd] for the accepted rd.
  - Then set pending[issue_rd] if issue_valid and issue_rd!=0.
  - Same register set and cleared in the same cycle: set wins.
- Protocol error: issue_valid with issue_rd!=0 while pending[issue_rd]=1 (WAW double claim) sets proto_err, which holds until reset. The bit remains set.
- Write-back of a register whose pending bit is 0: accepted normally, no error.
- Hazard (combinational): for rs in {chk_rs1, chk_rs2} with rs!=0, hazard=1 if either condition holds:
  - pending[rs]=1;
  - rf_write_enable=1 and rf_write_reg==rs. The register file commits on the clock edge, so a read in that cycle would return the stale value.
- x0 never raises hazard.
- No internal buffering. Throughput is one write per cycle. A losing requester stalls until granted; under continuous contention the grants alternate.

Decomposition:
- Package regfile_ctrl_pkg: XLEN, NUM_REGS, ADDR_W constants; grant enum {GNT_ALU, GNT_MEM}.
- Sub-module rr_arb2: two-requester round-robin arbiter, inputs req[1:0] and accept, outputs gnt[1:0], holds last_grant.
- The scoreboard, write register and hazard logic stay in the top module.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1 same cycle; next cycle rf_write_enable=1, rf_write_reg=5, rf_write_data=0xDEADBEEF; then rf_write_enable=0.
- alu_valid and mem_valid both held high for 4 cycles (rd=3 and 4) -> grants ALU, MEM, ALU, MEM; writes to x3, x4, x3, x4 each one cycle later.
- issue_valid, issue_rd=7; next cycle chk_rs1=7 -> hazard=1, pending[7]=1; mem write-back rd=7 accepted -> pending[7]=0 the next cycle, but hazard stays 1 during the rf_write cycle; hazard=0 the cycle after.
- issue_rd=9 claimed in the same cycle an ALU write-back to x9 is accepted -> pending[9]=1 afterwards (set wins); proto_err=0.
- ALU write-back rd=0, data=0x1234 -> alu_ready=1, rf_write_enable stays 0; chk_rs1=0 -> hazard=0; issue_rd=0 -> pending stays 0.
- Claim x12 twice without write-back -> proto_err=1 and sticky; reset asserted during an accepted write -> rf_write_enable=0 next cycle, pending=0, proto_err=0.
